// File: rtl/pattern_seq_ctrl.sv
// Pattern memory owner and playback sequencer: host writes while idle, step-triggered streaming otherwise.
// Optional build macro PATTERN_LOOP_EN adds i_loop for repeating playback until stop.
module pattern_seq_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_host_we,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [DATA_W-1:0] i_host_wdata,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [ADDR_W-1:0] i_length,
   input  logic              i_step,
`ifdef PATTERN_LOOP_EN
   input  logic              i_loop,
`endif
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_pat_data,
   output logic [ADDR_W-1:0] o_pat_index,
   output logic              o_pat_valid,
   input  logic              i_pat_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_host_err,
   output logic              o_step_ovr
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_READ    = 2'd2,
      S_PRESENT = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_index;
   logic [ADDR_W-1:0] r_len_q;
   logic [DATA_W-1:0] r_pat_data;
   logic              r_pat_valid;
   logic              r_done;
   logic              r_host_err;
   logic              r_step_ovr;
   logic              w_idle;
   logic              w_last;
   logic              w_loop;

   assign w_idle = (r_state == S_IDLE);
   assign w_last = (r_index == (r_len_q - ADDR_W'(1)));

`ifdef PATTERN_LOOP_EN
   logic r_loop_q;
   assign w_loop = r_loop_q;
`else
   assign w_loop = 1'b0;
`endif

   // Sequencer: stop has priority over every other request once playback is running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_index     <= '0;
         r_len_q     <= '0;
         r_pat_data  <= '0;
         r_pat_valid <= 1'b0;
         r_done      <= 1'b0;
         r_host_err  <= 1'b0;
         r_step_ovr  <= 1'b0;
`ifdef PATTERN_LOOP_EN
         r_loop_q    <= 1'b0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_host_err <= i_host_we && !w_idle;
         r_step_ovr <= i_step && (r_state != S_ARM);

         if (!w_idle && i_stop) begin
            r_state     <= S_IDLE;
            r_pat_valid <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     if (i_length == '0) begin
                        r_host_err <= 1'b1;
                     end else begin
                        r_state <= S_ARM;
                        r_index <= '0;
                        r_len_q <= i_length;
`ifdef PATTERN_LOOP_EN
                        r_loop_q <= i_loop;
`endif
                     end
                  end
               end
               S_ARM: begin
                  if (i_step) begin
                     r_state <= S_READ;
                  end
               end
               S_READ: begin
                  r_pat_data  <= i_mem_rdata;
                  r_pat_valid <= 1'b1;
                  r_state     <= S_PRESENT;
               end
               S_PRESENT: begin
                  if (i_pat_ready) begin
                     r_pat_valid <= 1'b0;
                     if (w_last) begin
                        r_done <= 1'b1;
                        if (w_loop) begin
                           r_index <= '0;
                           r_state <= S_ARM;
                        end else begin
                           r_state <= S_IDLE;
                        end
                     end else begin
                        r_index <= r_index + ADDR_W'(1);
                        r_state <= S_ARM;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Memory port belongs to the host only while idle; otherwise it is the read address.
   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_addr  = r_index;
      o_mem_wdata = i_host_wdata;
      if (w_idle) begin
         o_mem_we   = i_host_we;
         o_mem_addr = i_host_addr;
      end
   end

   assign o_pat_data  = r_pat_data;
   assign o_pat_index = r_index;
   assign o_pat_valid = r_pat_valid;
   assign o_busy      = !w_idle;
   assign o_done      = r_done;
   assign o_host_err  = r_host_err;
   assign o_step_ovr  = r_step_ovr;

endmodule
